// File: rtl/code_memory_loader.sv
// Loads 16-bit instruction words into code memory from a 4-bit valid/ready nibble stream.
// Holds the CPU from start until the DONE cycle; one memory write per assembled word.
module code_memory_loader #(
    parameter int ADDR_WIDTH   = 9,
    parameter int WORD_WIDTH   = 16,
    parameter int NIBBLE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_start,
    input  logic [NIBBLE_WIDTH-1:0] in_nibble,
    input  logic                    in_nibble_valid,
    input  logic                    in_last,
    output logic                    out_nibble_ready,
    output logic                    out_mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   out_mem_addr,
    output logic [WORD_WIDTH-1:0]   out_mem_data,
    output logic                    out_cpu_hold,
    output logic                    out_busy,
    output logic                    out_done,
    output logic                    out_error,
    output logic [ADDR_WIDTH:0]     out_word_count
);

    localparam int NIBBLES_PER_WORD = WORD_WIDTH / NIBBLE_WIDTH;
    localparam int CNT_WIDTH        = (NIBBLES_PER_WORD > 1) ? $clog2(NIBBLES_PER_WORD) : 1;
    localparam logic [CNT_WIDTH-1:0]  LAST_NIB = CNT_WIDTH'(NIBBLES_PER_WORD - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    if (WORD_WIDTH != NIBBLE_WIDTH * NIBBLES_PER_WORD) begin : g_width_check
        $error("WORD_WIDTH must be a whole number of nibbles");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0]    nib_cnt_q, nib_cnt_d;
    logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    last_q, last_d;
    logic                    error_q, error_d;
    logic [ADDR_WIDTH:0]     wcount_q, wcount_d;
    logic                    handshake;

    assign handshake = (state_q == S_COLLECT) && in_nibble_valid;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        nib_cnt_d = nib_cnt_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        error_d   = error_q;
        wcount_d  = wcount_q;

        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    state_d   = S_COLLECT;
                    addr_d    = '0;
                    wcount_d  = '0;
                    error_d   = 1'b0;
                    nib_cnt_d = '0;
                    last_d    = 1'b0;
                end
            end

            S_COLLECT: begin
                if (handshake) begin
                    shreg_d   = {shreg_q[WORD_WIDTH-NIBBLE_WIDTH-1:0], in_nibble};
                    nib_cnt_d = nib_cnt_q + 1'b1;
                    if (nib_cnt_q == LAST_NIB) begin
                        state_d   = S_WRITE;
                        last_d    = in_last;
                        nib_cnt_d = '0;
                    end else if (in_last) begin
                        // Program ended mid-word: drop the fragment, flag it
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                wcount_d = wcount_q + 1'b1;
                if (last_q) begin
                    state_d = S_DONE;
                end else if (addr_q == ADDR_MAX) begin
                    // Memory full with no end marker seen
                    state_d = S_DONE;
                    error_d = 1'b1;
                end else begin
                    state_d   = S_COLLECT;
                    addr_d    = addr_q + 1'b1;
                    nib_cnt_d = '0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            nib_cnt_q <= '0;
            shreg_q   <= '0;
            last_q    <= 1'b0;
            error_q   <= 1'b0;
            wcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            nib_cnt_q <= nib_cnt_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            error_q   <= error_d;
            wcount_q  <= wcount_d;
        end
    end

    assign out_nibble_ready = (state_q == S_COLLECT);
    assign out_mem_wr_en    = (state_q == S_WRITE);
    assign out_mem_addr     = addr_q;
    assign out_mem_data     = shreg_q;
    assign out_cpu_hold     = (state_q != S_IDLE);
    assign out_busy         = (state_q != S_IDLE);
    assign out_done         = (state_q == S_DONE);
    assign out_error        = error_q;
    assign out_word_count   = wcount_q;

endmodule

// File: tb/tb_code_memory_loader.sv
// Directed bench for code_memory_loader with a word-level reference model and a per-cycle monitor.
module tb_code_memory_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_start = 1'b0;
    logic [3:0]  in_nibble = 4'h0;
    logic        in_nibble_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_nibble_ready;
    logic        out_mem_wr_en;
    logic [8:0]  out_mem_addr;
    logic [15:0] out_mem_data;
    logic        out_cpu_hold;
    logic        out_busy;
    logic        out_done;
    logic        out_error;
    logic [9:0]  out_word_count;

    code_memory_loader #(.ADDR_WIDTH(9), .WORD_WIDTH(16), .NIBBLE_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_start(in_start),
        .in_nibble(in_nibble),
        .in_nibble_valid(in_nibble_valid),
        .in_last(in_last),
        .out_nibble_ready(out_nibble_ready),
        .out_mem_wr_en(out_mem_wr_en),
        .out_mem_addr(out_mem_addr),
        .out_mem_data(out_mem_data),
        .out_cpu_hold(out_cpu_hold),
        .out_busy(out_busy),
        .out_done(out_done),
        .out_error(out_error),
        .out_word_count(out_word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [3:0]  stim_n[$];
    bit          stim_l[$];
    wr_t         exp_q[$];
    bit          exp_err;
    int          exp_wc;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          wr_cyc = 0;
    int          hs_cyc = 0;
    logic [15:0] last_wr_data = 16'h0;
    bit          prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: turn the nibble list into the list of memory writes and final status
    task automatic model_load();
        int          a = 0;
        int          k = 0;
        logic [15:0] w = 16'h0;
        exp_q.delete();
        exp_err = 1'b0;
        exp_wc  = 0;
        for (int i = 0; i < stim_n.size(); i++) begin
            w = {w[11:0], stim_n[i]};
            k++;
            if (k == 4) begin
                exp_q.push_back('{addr: a, data: w});
                exp_wc++;
                k = 0;
                if (stim_l[i]) break;
                if (a == 511) begin
                    exp_err = 1'b1;
                    break;
                end
                a++;
            end else if (stim_l[i]) begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic add_word(input logic [15:0] w, input bit last);
        logic [15:0] t;
        t = w;
        for (int i = 3; i >= 0; i--) begin
            stim_n.push_back(t[i*4 +: 4]);
            stim_l.push_back(last && (i == 0));
        end
    endtask

    // Monitor: every cycle, writes must match the model in order; structural invariants hold
    always @(negedge clk) begin
        if (out_mem_wr_en) begin
            wr_cyc = cyc;
            last_wr_data = out_mem_data;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(out_mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(out_mem_addr), 32'(e.addr));
                chk("wr_data", 32'(out_mem_data), 32'(e.data));
            end
            chk("ready_in_write", 32'(out_nibble_ready), 32'd0);
        end
        chk("hold_eq_busy", 32'(out_cpu_hold), 32'(out_busy));
        if (out_done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_single_cycle", 32'(prev_done), 32'd0);
            chk("ready_in_done", 32'(out_nibble_ready), 32'd0);
        end
        prev_done = out_done;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(out_nibble_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(out_mem_wr_en), 32'd0);
        chk({tag, "_addr"},  32'(out_mem_addr), 32'd0);
        chk({tag, "_data"},  32'(out_mem_data), 32'd0);
        chk({tag, "_hold"},  32'(out_cpu_hold), 32'd0);
        chk({tag, "_busy"},  32'(out_busy), 32'd0);
        chk({tag, "_done"},  32'(out_done), 32'd0);
        chk({tag, "_error"}, 32'(out_error), 32'd0);
        chk({tag, "_wcount"}, 32'(out_word_count), 32'd0);
    endtask

    task automatic start_load();
        done_cnt = 0;
        @(negedge clk);
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        chk("busy_after_start", 32'(out_busy), 32'd1);
    endtask

    // Feed the stimulus list; optional valid toggling and an in_start pulse at nibble start_at
    task automatic feed(input bit stall, input int start_at);
        int idx = 0;
        int guard = 0;
        bit phase = 1'b0;
        while (idx < stim_n.size() && guard < 20000) begin
            @(negedge clk);
            guard++;
            in_start = (idx == start_at);
            if (stall && phase) begin
                in_nibble_valid = 1'b0;
                in_last = 1'b0;
            end else begin
                in_nibble_valid = 1'b1;
                in_nibble = stim_n[idx];
                in_last = stim_l[idx];
            end
            phase = !phase;
            if (in_nibble_valid && out_nibble_ready) begin
                hs_cyc = cyc;
                idx++;
            end
        end
        if (idx < stim_n.size()) chk("feed_timeout", 32'(idx), 32'(stim_n.size()));
        @(negedge clk);
        in_nibble_valid = 1'b0;
        in_last = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        int guard = 0;
        while (out_busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_end_timeout"}, 32'(out_busy), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_error"}, 32'(out_error), 32'(exp_err));
        chk({tag, "_wcount"}, 32'(out_word_count), 32'(exp_wc));
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_hold_idle"}, 32'(out_cpu_hold), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        // T1 single word
        stim_n.delete(); stim_l.delete();
        add_word(16'hABCD, 1'b1);
        model_load();
        chk("model_t1_data", 32'(exp_q[0].data), 32'hABCD);
        start_load();
        feed(1'b0, -1);
        finish_load("t1");
        chk("t1_wr_latency", 32'(wr_cyc - hs_cyc), 32'd1);
        chk("t1_done_latency", 32'(done_cyc - wr_cyc), 32'd1);
        chk("t1_last_data", 32'(last_wr_data), 32'hABCD);
        chk("t1_wcount_lit", 32'(out_word_count), 32'd1);

        // T2 three words with valid toggling
        stim_n.delete(); stim_l.delete();
        add_word(16'h1234, 1'b0);
        add_word(16'h5678, 1'b0);
        add_word(16'h9ABC, 1'b1);
        model_load();
        chk("model_t2_addr2", 32'(exp_q[2].addr), 32'd2);
        start_load();
        feed(1'b1, -1);
        finish_load("t2");
        chk("t2_last_data", 32'(last_wr_data), 32'h9ABC);
        chk("t2_wcount_lit", 32'(out_word_count), 32'd3);

        // T3 partial word
        stim_n.delete(); stim_l.delete();
        stim_n.push_back(4'h1); stim_l.push_back(1'b0);
        stim_n.push_back(4'h2); stim_l.push_back(1'b1);
        model_load();
        chk("model_t3_err", 32'(exp_err), 32'd1);
        start_load();
        feed(1'b0, -1);
        finish_load("t3");
        chk("t3_error_lit", 32'(out_error), 32'd1);

        // T6 start pulse mid-collect; also shows error cleared by the new start
        stim_n.delete(); stim_l.delete();
        add_word(16'hC0DE, 1'b0);
        add_word(16'hBEEF, 1'b1);
        model_load();
        start_load();
        chk("t6_error_cleared", 32'(out_error), 32'd0);
        feed(1'b0, 5);
        finish_load("t6");
        chk("t6_last_data", 32'(last_wr_data), 32'hBEEF);

        // T4 overflow: 512 words, no end marker
        stim_n.delete(); stim_l.delete();
        for (int i = 0; i < 512; i++) add_word(16'(i * 257) ^ 16'h5A5A, 1'b0);
        model_load();
        chk("model_t4_wc", 32'(exp_wc), 32'd512);
        start_load();
        feed(1'b0, -1);
        finish_load("t4");
        chk("t4_error_lit", 32'(out_error), 32'd1);
        chk("t4_wcount_lit", 32'(out_word_count), 32'd512);
        chk("t4_last_data", 32'(last_wr_data), 32'(16'(511 * 257) ^ 16'h5A5A));

        // T5 reset after 6 nibbles
        stim_n.delete(); stim_l.delete();
        add_word(16'h1357, 1'b0);
        stim_n.push_back(4'h2); stim_l.push_back(1'b0);
        stim_n.push_back(4'h4); stim_l.push_back(1'b0);
        model_load();
        start_load();
        feed(1'b0, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("t5_after_rst");
        chk("t5_writes_left", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        chk("t5_idle", 32'(out_busy), 32'd0);

        // Reload after reset starts from address 0
        stim_n.delete(); stim_l.delete();
        add_word(16'h0F0F, 1'b1);
        model_load();
        start_load();
        feed(1'b0, -1);
        finish_load("t5b");
        chk("t5b_last_data", 32'(last_wr_data), 32'h0F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
